issue_scoreboard: RTL and testbench
===================================

// Module: issue_scoreboard
// PURPOSE
//  In-order issue controller between decode and the execution units of the RV32IMF core.
//  Classifies each instruction_t by opcode and funct7 into a unit (ALU/MULDIV/FPU/LSU).
//  Tracks pending writes to X1..X31 and F0..F31 in busy bitmaps; stalls issue on RAW/WAW hazards.
//  Serializes FENCE_O/ECSR by draining in-flight writes; handles writeback clear and flush.
// PARAMETERS
//  MAX_OUTSTANDING  4  max in-flight register-writing instructions (1..15)
// PORTS
//  clk_i            in   1   clock
//  rst_n_i          in   1   async reset, active low
//  flush_i          in   1   sync flush: clear busy maps, counter, FSM
//  instr_i          in   32  decoded instruction word (instruction_t)
//  instr_valid_i    in   1   instr_i valid
//  instr_ready_o    out  1   instr_i consumed this cycle (== issue fire)
//  issue_valid_o    out  1   instruction dispatched to issue_unit_o
//  issue_unit_o     out  2   0 ALU, 1 MULDIV, 2 FPU, 3 LSU
//  unit_ready_i     in   4   per-unit accept, indexed by unit code
//  int_wb_valid_i   in   1   integer writeback
//  int_wb_rd_i      in   5   integer writeback register, never X0
//  fp_wb_valid_i    in   1   FP writeback
//  fp_wb_rd_i       in   5   FP writeback register
//  stall_o          out  1   instr_valid_i high and no issue this cycle
//  illegal_o        out  1   issued opcode outside opcode_e (1-cycle pulse)
//  outstanding_o    out  4   in-flight write count
// BEHAVIOUR
//  Reset: busy maps 0, count 0, FSM=RUN; all outputs 0.
//  Operand and unit decode by opcode:
//   - LUI/AUIPC/JAL: int rd, ALU. JALR/ALU_I: int rs1, int rd, ALU. BRANCH: int rs1, rs2, ALU.
//   - REG_OP: int rs1, rs2, rd; MULDIV if funct7=F7_M, else ALU.
//   - LOAD: int rs1, int rd. STORE: int rs1, rs2. FLOAD: int rs1, fp rd.
//     FSTORE: int rs1, fp rs2. All four go to LSU.
//   - FMADD/FMSUB/FNMSUB/FNMADD: fp rs1, rs2, rs3, rd, FPU.
//   - F_OPS, FPU: FCVTW/FMV_CLS/FCMP -> fp rs1, int rd. FCVTS/FMVWX -> int rs1, fp rd.
//     FSQRT -> fp rs1, fp rd. Other F_OPS -> fp rs1, rs2, rd.
//   - FENCE_O/ECSR: serializing, ALU; ECSR writes int rd.
//   - Unknown opcode: ALU, no operands, illegal_o=1 on fire.
//  Int rd=X0 is never a write target. X0 is never busy.
//  hazard = any read source busy, or destination busy (WAW).
//  fire = instr_valid_i & !hazard & unit_ready_i[unit] & count<MAX_OUTSTANDING & state-ok & !flush_i.
//   - The count limit applies only to instructions that write a register.
//  Issue is combinational, same cycle: issue_valid_o = instr_ready_o = fire.
//  Unit outputs are valid only while issue_valid_o is high.
//  On fire with a destination: set busy bit and count++ at the next clock edge.
//  On wb_valid: clear the busy bit and count-- at the next clock edge.
//  Both wb ports plus an issue in one cycle: count += set - clears (net).
//  Same-register clear and set in one cycle: set wins. Cannot arise without WB_BYPASS_EN.
//  Writeback to a non-busy register: ignored, count unchanged. Count saturates at 0.
//  FSM:
//   - RUN: a serializing instr with count!=0 -> DRAIN, not issued; others issue normally.
//   - RUN: a serializing instr with count==0 issues immediately and stays in RUN.
//   - DRAIN: nothing issues; count==0 -> RUN, and the instr issues there next cycle.
//  flush_i has priority over all: next edge busy=0, count=0, FSM=RUN; no fire in the flush cycle.
//   - Writebacks in the flush cycle are discarded.
//  Reset mid-operation: immediate clear, same as flush.
// CONFIGURATION
//  ISSUE_WB_BYPASS_EN defined: a same-cycle writeback clears that register for the hazard check.
//   - A dependent instruction issues in the writeback cycle.
//   - Same-register clear+set: bit ends busy, count unchanged.
//  Undefined: hazard check uses registered busy bits only; dependent issues 1 cycle after writeback.
// TESTING
//  ADDI x5 issue, then ADD x6,x5,x1 -> stall_o=1 until int_wb x5.
//   - Issue at wb+1, or at the wb cycle with ISSUE_WB_BYPASS_EN.
//  FLW f3 then FADD f4,f3,f2 -> FADD stalls until fp_wb f3. FCVT.W.S x7,f4 stalls on f4 only.
//  MAX_OUTSTANDING=4, five independent ADDIs, no wb -> 4 issue, 5th stalls.
//   - outstanding_o=4; one wb -> 5th issues next cycle.
//  MUL with unit_ready_i[1]=0 -> stall. Raise it -> issue_unit_o=1 that cycle.
//  ADDI x9, then FENCE -> FSM DRAIN, no issue.
//   - After wb x9, FENCE issues next cycle; the instr after FENCE issues the cycle after.
//  Three pending writes, assert flush_i -> outstanding_o=0 and busy clear next cycle.
//   - Dependent instr then issues immediately. Opcode 7'b1111111 -> illegal_o pulse.

Source files
------------

// File: rtl/issue_scoreboard.sv
// In-order RV32IMF issue scoreboard: unit classification, X/F busy maps, RAW/WAW stalls, FENCE/CSR drain.
// Optional build macro ISSUE_WB_BYPASS_EN lets a same-cycle writeback clear a hazard.
module issue_scoreboard #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        flush_i,
    input  logic [31:0] instr_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    output logic        issue_valid_o,
    output logic [1:0]  issue_unit_o,
    input  logic [3:0]  unit_ready_i,
    input  logic        int_wb_valid_i,
    input  logic [4:0]  int_wb_rd_i,
    input  logic        fp_wb_valid_i,
    input  logic [4:0]  fp_wb_rd_i,
    output logic        stall_o,
    output logic        illegal_o,
    output logic [3:0]  outstanding_o
);

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_ALU_I  = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_FENCE  = 7'b0001111,
        OP_ECSR   = 7'b1110011,
        OP_FLOAD  = 7'b0000111,
        OP_FSTORE = 7'b0100111,
        OP_FMADD  = 7'b1000011,
        OP_FMSUB  = 7'b1000111,
        OP_FNMSUB = 7'b1001011,
        OP_FNMADD = 7'b1001111,
        OP_F_OPS  = 7'b1010011
    } opcode_e;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instruction_t;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    localparam logic [6:0] F7_M       = 7'b0000001;
    localparam logic [6:0] F7_FCVTW   = 7'b1100000;
    localparam logic [6:0] F7_FMV_CLS = 7'b1110000;
    localparam logic [6:0] F7_FCMP    = 7'b1010000;
    localparam logic [6:0] F7_FCVTS   = 7'b1101000;
    localparam logic [6:0] F7_FMVWX   = 7'b1111000;
    localparam logic [6:0] F7_FSQRT   = 7'b0101100;

    localparam logic [1:0] UNIT_ALU    = 2'd0;
    localparam logic [1:0] UNIT_MULDIV = 2'd1;
    localparam logic [1:0] UNIT_FPU    = 2'd2;
    localparam logic [1:0] UNIT_LSU    = 2'd3;

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    instruction_t instr_s;
    logic [4:0]   rs3_s;
    logic         unused_funct3_s;

    logic        rs1_int_s, rs2_int_s, rs1_fp_s, rs2_fp_s, rs3_fp_s;
    logic        rd_int_s, rd_fp_s, int_write_s, writes_s;
    logic [1:0]  unit_s;
    logic        serial_s, illegal_s;

    logic [31:0] busy_int_r, busy_fp_r;
    logic [3:0]  count_r;
    state_e      state_r;

    logic [31:0] int_clr_s, fp_clr_s, int_view_s, fp_view_s, int_set_s, fp_set_s;
    logic        hazard_s, cap_ok_s, state_ok_s, fire_s;
    logic [4:0]  cnt_up_s, cnt_dn_s, count_nxt_s;

    assign instr_s         = instr_i;
    assign rs3_s           = instr_s.funct7[6:2];
    assign unused_funct3_s = ^instr_s.funct3;

    // Operand usage and execution unit from opcode / funct7.
    always_comb begin
        rs1_int_s = 1'b0;
        rs2_int_s = 1'b0;
        rs1_fp_s  = 1'b0;
        rs2_fp_s  = 1'b0;
        rs3_fp_s  = 1'b0;
        rd_int_s  = 1'b0;
        rd_fp_s   = 1'b0;
        unit_s    = UNIT_ALU;
        serial_s  = 1'b0;
        illegal_s = 1'b0;
        case (instr_s.opcode)
            OP_LUI, OP_AUIPC, OP_JAL: rd_int_s = 1'b1;
            OP_JALR, OP_ALU_I: begin
                rs1_int_s = 1'b1;
                rd_int_s  = 1'b1;
            end
            OP_BRANCH: begin
                rs1_int_s = 1'b1;
                rs2_int_s = 1'b1;
            end
            OP_REG: begin
                rs1_int_s = 1'b1;
                rs2_int_s = 1'b1;
                rd_int_s  = 1'b1;
                if (instr_s.funct7 == F7_M) begin
                    unit_s = UNIT_MULDIV;
                end else begin
                    unit_s = UNIT_ALU;
                end
            end
            OP_LOAD: begin
                rs1_int_s = 1'b1;
                rd_int_s  = 1'b1;
                unit_s    = UNIT_LSU;
            end
            OP_STORE: begin
                rs1_int_s = 1'b1;
                rs2_int_s = 1'b1;
                unit_s    = UNIT_LSU;
            end
            OP_FLOAD: begin
                rs1_int_s = 1'b1;
                rd_fp_s   = 1'b1;
                unit_s    = UNIT_LSU;
            end
            OP_FSTORE: begin
                rs1_int_s = 1'b1;
                rs2_fp_s  = 1'b1;
                unit_s    = UNIT_LSU;
            end
            OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD: begin
                rs1_fp_s = 1'b1;
                rs2_fp_s = 1'b1;
                rs3_fp_s = 1'b1;
                rd_fp_s  = 1'b1;
                unit_s   = UNIT_FPU;
            end
            OP_F_OPS: begin
                unit_s = UNIT_FPU;
                case (instr_s.funct7)
                    F7_FCVTW, F7_FMV_CLS, F7_FCMP: begin
                        rs1_fp_s = 1'b1;
                        rd_int_s = 1'b1;
                    end
                    F7_FCVTS, F7_FMVWX: begin
                        rs1_int_s = 1'b1;
                        rd_fp_s   = 1'b1;
                    end
                    F7_FSQRT: begin
                        rs1_fp_s = 1'b1;
                        rd_fp_s  = 1'b1;
                    end
                    default: begin
                        rs1_fp_s = 1'b1;
                        rs2_fp_s = 1'b1;
                        rd_fp_s  = 1'b1;
                    end
                endcase
            end
            OP_FENCE: serial_s = 1'b1;
            OP_ECSR: begin
                serial_s = 1'b1;
                rd_int_s = 1'b1;
            end
            default: illegal_s = 1'b1;
        endcase
    end

    assign int_write_s = rd_int_s & (instr_s.rd != 5'd0);
    assign writes_s    = int_write_s | rd_fp_s;

    // Writebacks only count against registers that are actually pending.
    assign int_clr_s = int_wb_valid_i ? ((32'b1 << int_wb_rd_i) & busy_int_r) : 32'b0;
    assign fp_clr_s  = fp_wb_valid_i  ? ((32'b1 << fp_wb_rd_i)  & busy_fp_r)  : 32'b0;

`ifdef ISSUE_WB_BYPASS_EN
    assign int_view_s = busy_int_r & ~int_clr_s;
    assign fp_view_s  = busy_fp_r  & ~fp_clr_s;
`else
    assign int_view_s = busy_int_r;
    assign fp_view_s  = busy_fp_r;
`endif

    assign hazard_s = (rs1_int_s   & int_view_s[instr_s.rs1]) |
                      (rs2_int_s   & int_view_s[instr_s.rs2]) |
                      (rs1_fp_s    & fp_view_s[instr_s.rs1])  |
                      (rs2_fp_s    & fp_view_s[instr_s.rs2])  |
                      (rs3_fp_s    & fp_view_s[rs3_s])        |
                      (int_write_s & int_view_s[instr_s.rd])  |
                      (rd_fp_s     & fp_view_s[instr_s.rd]);

    assign cap_ok_s = ~writes_s | (count_r < MAX_CNT);

    // Serializing instructions may only leave RUN with nothing in flight.
    always_comb begin
        state_ok_s = 1'b0;
        case (state_r)
            ST_RUN:   state_ok_s = ~serial_s | (count_r == 4'd0);
            ST_DRAIN: state_ok_s = 1'b0;
            default:  state_ok_s = 1'b0;
        endcase
    end

    assign fire_s = instr_valid_i & ~hazard_s & unit_ready_i[unit_s] & cap_ok_s & state_ok_s & ~flush_i;

    assign int_set_s = (fire_s & int_write_s) ? (32'b1 << instr_s.rd) : 32'b0;
    assign fp_set_s  = (fire_s & rd_fp_s)     ? (32'b1 << instr_s.rd) : 32'b0;

    assign cnt_up_s    = {1'b0, count_r} + {4'b0, fire_s & writes_s};
    assign cnt_dn_s    = {4'b0, |int_clr_s} + {4'b0, |fp_clr_s};
    assign count_nxt_s = (cnt_up_s >= cnt_dn_s) ? (cnt_up_s - cnt_dn_s) : 5'd0;

    // Busy maps, in-flight count and drain FSM; set wins over a same-register clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_int_r <= 32'b0;
            busy_fp_r  <= 32'b0;
            count_r    <= 4'd0;
            state_r    <= ST_RUN;
        end else if (flush_i) begin
            busy_int_r <= 32'b0;
            busy_fp_r  <= 32'b0;
            count_r    <= 4'd0;
            state_r    <= ST_RUN;
        end else begin
            busy_int_r <= ((busy_int_r & ~int_clr_s) | int_set_s) & ~32'b1;
            busy_fp_r  <= (busy_fp_r & ~fp_clr_s) | fp_set_s;
            count_r    <= count_nxt_s[3:0];
            case (state_r)
                ST_RUN: begin
                    if (instr_valid_i && serial_s && (count_r != 4'd0)) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (count_nxt_s == 5'd0) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: state_r <= ST_RUN;
            endcase
        end
    end

    assign issue_valid_o = fire_s;
    assign instr_ready_o = fire_s;
    assign issue_unit_o  = fire_s ? unit_s : 2'd0;
    assign stall_o       = instr_valid_i & ~fire_s;
    assign illegal_o     = fire_s & illegal_s;
    assign outstanding_o = count_r;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed self-checking bench for issue_scoreboard (MAX_OUTSTANDING=4).
module tb_issue_scoreboard;

    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_FLOAD = 7'b0000111;
    localparam logic [6:0] OP_FOPS  = 7'b1010011;
    localparam logic [6:0] OP_FENCE = 7'b0001111;
    localparam logic [6:0] OP_ECSR  = 7'b1110011;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] instr_i = 32'b0;
    logic        instr_valid_i = 1'b0;
    logic        instr_ready_o;
    logic        issue_valid_o;
    logic [1:0]  issue_unit_o;
    logic [3:0]  unit_ready_i = 4'b1111;
    logic        int_wb_valid_i = 1'b0;
    logic [4:0]  int_wb_rd_i = 5'd0;
    logic        fp_wb_valid_i = 1'b0;
    logic [4:0]  fp_wb_rd_i = 5'd0;
    logic        stall_o;
    logic        illegal_o;
    logic [3:0]  outstanding_o;

    int n_checks = 0;
    int n_fail = 0;

    issue_scoreboard #(.MAX_OUTSTANDING(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .instr_i(instr_i), .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .issue_valid_o(issue_valid_o), .issue_unit_o(issue_unit_o), .unit_ready_i(unit_ready_i),
        .int_wb_valid_i(int_wb_valid_i), .int_wb_rd_i(int_wb_rd_i),
        .fp_wb_valid_i(fp_wb_valid_i), .fp_wb_rd_i(fp_wb_rd_i),
        .stall_o(stall_o), .illegal_o(illegal_o), .outstanding_o(outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        instr_valid_i  = 1'b0;
        flush_i        = 1'b0;
        int_wb_valid_i = 1'b0;
        fp_wb_valid_i  = 1'b0;
        unit_ready_i   = 4'b1111;
    endtask

    task automatic do_flush();
        idle();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_n_i = 1'b0;
        #3;
        n_checks++;
        if ({issue_valid_o, instr_ready_o, stall_o, illegal_o, issue_unit_o, outstanding_o} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {issue_valid_o, instr_ready_o, stall_o, illegal_o, issue_unit_o, outstanding_o}, 10'b0);
        end
        tick();
        tick();
        rst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_raw_int();
        idle();
        instr_i = enc(7'd0, 5'd0, 5'd0, 3'b000, 5'd5, OP_ALUI);
        instr_valid_i = 1'b1;
        settle();
        n_checks++;
        if ({issue_valid_o, instr_ready_o, stall_o, issue_unit_o} !== {1'b1, 1'b1, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL addi_issue: got %b expected 11000", {issue_valid_o, instr_ready_o, stall_o, issue_unit_o});
        end
        tick();
        instr_i = enc(7'd0, 5'd1, 5'd5, 3'b000, 5'd6, OP_REG);
        settle();
        n_checks++;
        if ({issue_valid_o, stall_o, outstanding_o} !== {1'b0, 1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL add_raw_stall: got %b expected 010001", {issue_valid_o, stall_o, outstanding_o});
        end
        tick();
        int_wb_valid_i = 1'b1;
        int_wb_rd_i = 5'd5;
        settle();
`ifdef ISSUE_WB_BYPASS_EN
        n_checks++;
        if (issue_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL add_bypass_issue: got %b expected 1", issue_valid_o);
        end
        tick();
        int_wb_valid_i = 1'b0;
`else
        n_checks++;
        if ({issue_valid_o, stall_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL add_wb_cycle_stall: got %b expected 01", {issue_valid_o, stall_o});
        end
        tick();
        int_wb_valid_i = 1'b0;
        settle();
        n_checks++;
        if ({issue_valid_o, stall_o, outstanding_o} !== {1'b1, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL add_issue_after_wb: got %b expected 100000", {issue_valid_o, stall_o, outstanding_o});
        end
        tick();
`endif
        idle();
        settle();
        n_checks++;
        if (outstanding_o !== 4'd1) begin
            n_fail++;
            $display("FAIL add_dest_pending: got %0d expected 1", outstanding_o);
        end
        int_wb_valid_i = 1'b1;
        int_wb_rd_i = 5'd6;
        tick();
        idle();
        settle();
        n_checks++;
        if (outstanding_o !== 4'd0) begin
            n_fail++;
            $display("FAIL wb_x6_clear: got %0d expected 0", outstanding_o);
        end
    endtask

    task automatic test_fp_raw();
        idle();
        instr_valid_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            instr_i = enc(7'd0, 5'd0, 5'd0, 3'b010, (i == 0) ? 5'd3 : 5'd5, OP_FLOAD);
            settle();
            n_checks++;
            if ({issue_valid_o, issue_unit_o} !== {1'b1, 2'd3}) begin
                n_fail++;
                $display("FAIL flw_issue_%0d: got %b expected 111", i, {issue_valid_o, issue_unit_o});
            end
            tick();
        end
        instr_i = enc(7'b0000000, 5'd2, 5'd3, 3'b000, 5'd4, OP_FOPS);
        settle();
        n_checks++;
        if (stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL fadd_raw_stall: got %b expected 1", stall_o);
        end
        tick();
        fp_wb_valid_i = 1'b1;
        fp_wb_rd_i = 5'd3;
`ifndef ISSUE_WB_BYPASS_EN
        settle();
        tick();
        fp_wb_valid_i = 1'b0;
`endif
        settle();
        n_checks++;
        if ({issue_valid_o, issue_unit_o} !== {1'b1, 2'd2}) begin
            n_fail++;
            $display("FAIL fadd_issue: got %b expected 110", {issue_valid_o, issue_unit_o});
        end
        tick();
        fp_wb_valid_i = 1'b0;
        // rs2 field names f5 (still busy) but FCVT.W.S reads only rs1
        instr_i = enc(7'b1100000, 5'd5, 5'd4, 3'b000, 5'd7, OP_FOPS);
        settle();
        n_checks++;
        if ({issue_valid_o, stall_o, outstanding_o} !== {1'b0, 1'b1, 4'd2}) begin
            n_fail++;
            $display("FAIL fcvt_raw_stall: got %b expected 010010", {issue_valid_o, stall_o, outstanding_o});
        end
        tick();
        fp_wb_valid_i = 1'b1;
        fp_wb_rd_i = 5'd4;
`ifndef ISSUE_WB_BYPASS_EN
        settle();
        tick();
        fp_wb_valid_i = 1'b0;
`endif
        settle();
        n_checks++;
        if ({issue_valid_o, issue_unit_o} !== {1'b1, 2'd2}) begin
            n_fail++;
            $display("FAIL fcvt_issue_f4_only: got %b expected 110", {issue_valid_o, issue_unit_o});
        end
        tick();
        do_flush();
    endtask

    task automatic test_max_outstanding();
        idle();
        instr_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instr_i = enc(7'd0, 5'd0, 5'd0, 3'b000, 5'(10 + i), OP_ALUI);
            settle();
            n_checks++;
            if (issue_valid_o !== 1'b1) begin
                n_fail++;
                $display("FAIL max_addi_%0d_issue: got %b expected 1", i, issue_valid_o);
            end
            tick();
        end
        instr_i = enc(7'd0, 5'd0, 5'd0, 3'b000, 5'd14, OP_ALUI);
        settle();
        n_checks++;
        if ({issue_valid_o, stall_o, outstanding_o} !== {1'b0, 1'b1, 4'd4}) begin
            n_fail++;
            $display("FAIL max_fifth_stall: got %b expected 010100", {issue_valid_o, stall_o, outstanding_o});
        end
        tick();
        instr_i = enc(7'd0, 5'd0, 5'd0, 3'b010, 5'd0, OP_STORE);
        settle();
        n_checks++;
        if ({issue_valid_o, issue_unit_o} !== {1'b1, 2'd3}) begin
            n_fail++;
            $display("FAIL max_store_no_rd_issue: got %b expected 111", {issue_valid_o, issue_unit_o});
        end
        tick();
        instr_i = enc(7'd0, 5'd0, 5'd0, 3'b000, 5'd14, OP_ALUI);
        int_wb_valid_i = 1'b1;
        int_wb_rd_i = 5'd10;
        settle();
        n_checks++;
        if (stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL max_wb_cycle_stall: got %b expected 1", stall_o);
        end
        tick();
        int_wb_valid_i = 1'b0;
        settle();
        n_checks++;
        if ({issue_valid_o, outstanding_o} !== {1'b1, 4'd3}) begin
            n_fail++;
            $display("FAIL max_fifth_issue: got %b expected 10011", {issue_valid_o, outstanding_o});
        end
        tick();
        do_flush();
    endtask

    task automatic test_unit_ready();
        idle();
        instr_i = enc(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd20, OP_REG);
        instr_valid_i = 1'b1;
        unit_ready_i = 4'b1101;
        settle();
        n_checks++;
        if ({issue_valid_o, stall_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL mul_unit_busy_stall: got %b expected 01", {issue_valid_o, stall_o});
        end
        tick();
        unit_ready_i = 4'b1111;
        settle();
        n_checks++;
        if ({issue_valid_o, issue_unit_o} !== {1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL mul_issue_unit: got %b expected 101", {issue_valid_o, issue_unit_o});
        end
        tick();
        do_flush();
    endtask

    task automatic test_fence();
        idle();
        instr_i = enc(7'd0, 5'd0, 5'd0, 3'b000, 5'd9, OP_ALUI);
        instr_valid_i = 1'b1;
        tick();
        instr_i = enc(7'd0, 5'd0, 5'd0, 3'b000, 5'd0, OP_FENCE);
        for (int i = 0; i < 2; i++) begin
            settle();
            n_checks++;
            if ({issue_valid_o, stall_o, outstanding_o} !== {1'b0, 1'b1, 4'd1}) begin
                n_fail++;
                $display("FAIL fence_drain_%0d: got %b expected 010001", i, {issue_valid_o, stall_o, outstanding_o});
            end
            tick();
        end
        int_wb_valid_i = 1'b1;
        int_wb_rd_i = 5'd9;
        settle();
        n_checks++;
        if (stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL fence_wb_cycle_stall: got %b expected 1", stall_o);
        end
        tick();
        int_wb_valid_i = 1'b0;
        settle();
        n_checks++;
        if ({issue_valid_o, issue_unit_o, outstanding_o} !== {1'b1, 2'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL fence_issue: got %b expected 1000000", {issue_valid_o, issue_unit_o, outstanding_o});
        end
        tick();
        instr_i = enc(7'd0, 5'd0, 5'd0, 3'b000, 5'd1, OP_ALUI);
        settle();
        n_checks++;
        if (issue_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL after_fence_issue: got %b expected 1", issue_valid_o);
        end
        tick();
        do_flush();
    endtask

    task automatic test_flush();
        idle();
        instr_valid_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            instr_i = enc(7'd0, 5'd0, 5'd0, 3'b000, 5'(i), OP_ALUI);
            tick();
        end
        instr_i = enc(7'd0, 5'd2, 5'd1, 3'b000, 5'd4, OP_REG);
        flush_i = 1'b1;
        int_wb_valid_i = 1'b1;
        int_wb_rd_i = 5'd1;
        settle();
        n_checks++;
        if ({issue_valid_o, stall_o, outstanding_o} !== {1'b0, 1'b1, 4'd3}) begin
            n_fail++;
            $display("FAIL flush_cycle_no_fire: got %b expected 010011", {issue_valid_o, stall_o, outstanding_o});
        end
        tick();
        flush_i = 1'b0;
        int_wb_valid_i = 1'b0;
        settle();
        n_checks++;
        if ({issue_valid_o, outstanding_o} !== {1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL flush_then_issue: got %b expected 10000", {issue_valid_o, outstanding_o});
        end
        tick();
        idle();
        int_wb_valid_i = 1'b1;
        int_wb_rd_i = 5'd1;
        tick();
        int_wb_valid_i = 1'b0;
        settle();
        n_checks++;
        if (outstanding_o !== 4'd1) begin
            n_fail++;
            $display("FAIL wb_non_busy_ignored: got %0d expected 1", outstanding_o);
        end
        int_wb_valid_i = 1'b1;
        int_wb_rd_i = 5'd4;
        tick();
        idle();
        settle();
        n_checks++;
        if (outstanding_o !== 4'd0) begin
            n_fail++;
            $display("FAIL wb_x4_clear: got %0d expected 0", outstanding_o);
        end
    endtask

    task automatic test_illegal_x0_csr();
        idle();
        instr_i = 32'h0000007F;
        instr_valid_i = 1'b1;
        settle();
        n_checks++;
        if ({issue_valid_o, illegal_o, issue_unit_o} !== {1'b1, 1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL illegal_pulse: got %b expected 1100", {issue_valid_o, illegal_o, issue_unit_o});
        end
        tick();
        instr_i = enc(7'd0, 5'd0, 5'd0, 3'b000, 5'd0, OP_ALUI);
        settle();
        n_checks++;
        if ({issue_valid_o, illegal_o, outstanding_o} !== {1'b1, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL addi_x0_issue: got %b expected 100000", {issue_valid_o, illegal_o, outstanding_o});
        end
        tick();
        instr_i = enc(7'd0, 5'd0, 5'd0, 3'b001, 5'd8, OP_ECSR);
        settle();
        n_checks++;
        if ({issue_valid_o, outstanding_o} !== {1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL csr_idle_issue: got %b expected 10000", {issue_valid_o, outstanding_o});
        end
        tick();
        instr_i = enc(7'd0, 5'd0, 5'd8, 3'b000, 5'd9, OP_REG);
        settle();
        n_checks++;
        if ({issue_valid_o, stall_o, outstanding_o} !== {1'b0, 1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL csr_rd_raw_stall: got %b expected 010001", {issue_valid_o, stall_o, outstanding_o});
        end
        tick();
        do_flush();
    endtask

    initial begin
        test_reset();
        test_raw_int();
        test_fp_raw();
        test_max_outstanding();
        test_unit_ready();
        test_fence();
        test_flush();
        test_illegal_x0_csr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
